vram_rd_arb: RTL and testbench
==============================

VRAM_RD_ARB -- requirements
Module: vram_rd_arb

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, max consecutive M0 grants while M1 waits; legal range 1..15.
REQ-002 ACLK  input  1  clock; all state updates on rising edge.
REQ-003 ARST  input  1  reset, synchronous, active-high.
REQ-004 M0_ARADDR  input  32  display-fetch read address.
REQ-005 M0_ARVALID  input  1 / M0_ARREADY  output  1  display AR handshake.
REQ-006 M0_RVALID  output  1 / M0_RLAST  output  1 / M0_RREADY  input  1  display R handshake.
REQ-007 M1_ARADDR  input  32 / M1_ARVALID  input  1 / M1_ARREADY  output  1  draw-engine AR channel.
REQ-008 M1_RVALID  output  1 / M1_RLAST  output  1 / M1_RREADY  input  1  draw-engine R handshake.
REQ-009 ARADDR  output  32 / ARVALID  output  1 / ARREADY  input  1  shared VRAM AR channel.
REQ-010 RVALID  input  1 / RLAST  input  1 / RREADY  output  1  shared VRAM R handshake; RDATA routes to both masters outside this block.
REQ-011 GRANT  output  2  one-hot owner (bit0 = M0, bit1 = M1), 2'b00 when idle.
REQ-012 BUSY  output  1  high while any burst is in ADDR or DATA.

Function
REQ-013 FSM states SHALL be IDLE, ADDR, DATA, one-hot encoded.
REQ-014 IDLE: if any Mx_ARVALID, SHALL register the winner into GRANT and move to ADDR next cycle; otherwise stay in IDLE.
REQ-015 Arbitration: M0 SHALL win by default; M1 SHALL win when only M1 requests, or when both request and STARVE_CNT == STARVE_LIMIT.
REQ-016 STARVE_CNT (4 bits) SHALL increment on each M0 grant made while M1_ARVALID is high, clear on any M1 grant, clear when M1_ARVALID is low in IDLE, and saturate at STARVE_LIMIT.
REQ-017 ADDR: ARADDR/ARVALID SHALL mirror the granted master combinationally; the granted Mx_ARREADY SHALL equal ARREADY; the other Mx_ARREADY SHALL be 0.
REQ-018 ADDR -> DATA on ARVALID & ARREADY; remain in ADDR otherwise (grant held, no re-arbitration).
REQ-019 DATA: granted Mx_RVALID/Mx_RLAST SHALL equal RVALID/RLAST; RREADY SHALL equal the granted Mx_RREADY; non-granted Mx_RVALID/Mx_RLAST SHALL be 0.
REQ-020 DATA -> IDLE on RVALID & RREADY & RLAST; GRANT SHALL clear to 00 in the same edge.
REQ-021 Exactly one burst SHALL be outstanding; a new grant SHALL not occur before the IDLE cycle following RLAST.
REQ-022 Latency: Mx_ARVALID rising in IDLE at cycle t SHALL produce ARVALID at cycle t+1; back-to-back bursts SHALL be separated by exactly one IDLE cycle.
REQ-023 Outside ADDR, ARVALID and ARADDR SHALL be 0; outside DATA, RREADY and all Mx_RVALID/Mx_RLAST SHALL be 0.
REQ-024 A master's ARVALID deasserting while granted in ADDR is a protocol violation; behaviour SHALL be to hold the grant (no abort).
REQ-025 RVALID in IDLE or ADDR SHALL be ignored and SHALL not be forwarded.
REQ-026 BUSY SHALL be high exactly when state is ADDR or DATA.

Reset
REQ-027 ARST high at an edge SHALL force IDLE, GRANT = 00, STARVE_CNT = 0, regardless of state, including mid-burst.
REQ-028 During and immediately after reset, ARVALID, RREADY, M0_ARREADY, M1_ARREADY, M0_RVALID, M1_RVALID, M0_RLAST, M1_RLAST and BUSY SHALL be 0.
REQ-029 The first arbitration SHALL occur in the first IDLE cycle after ARST deasserts.

Verification
REQ-030 M0 only, M0_ARADDR = 0x1000_0000, ARREADY = 1, 8-beat burst -> ARVALID at t+1 with ARADDR 0x1000_0000, GRANT = 01, 8 beats forwarded to M0, IDLE after RLAST.
REQ-031 Both request continuously, STARVE_LIMIT = 4 -> grant sequence M0, M0, M0, M0, M1, M0..., with STARVE_CNT cleared after the M1 grant.
REQ-032 ARREADY held low 5 cycles in ADDR -> ARVALID stays high, ARADDR stays stable, GRANT does not change, and the other master sees ARREADY = 0.
REQ-033 RREADY from the granted master toggling with RVALID held high -> beats transfer only when both are high, and the non-granted master sees RVALID = 0.
REQ-034 ARST asserted at beat 3 of an M1 burst -> next cycle IDLE, GRANT = 00, all handshake outputs 0, and M0 is granted first after release.
REQ-035 Stray RVALID in IDLE -> RREADY = 0 and no Mx_RVALID pulse.

Source files
------------

// File: rtl/vram_rd_arb.sv
// Two-master read arbiter for the shared VRAM AR/R channels: display fetch (M0) has
// priority, draw engine (M1) is guaranteed a grant after STARVE_LIMIT consecutive M0 wins.
module vram_rd_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic [31:0] M0_ARADDR,
  input  logic        M0_ARVALID,
  output logic        M0_ARREADY,
  output logic        M0_RVALID,
  output logic        M0_RLAST,
  input  logic        M0_RREADY,
  input  logic [31:0] M1_ARADDR,
  input  logic        M1_ARVALID,
  output logic        M1_ARREADY,
  output logic        M1_RVALID,
  output logic        M1_RLAST,
  input  logic        M1_RREADY,
  output logic [31:0] ARADDR,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic        RVALID,
  input  logic        RLAST,
  output logic        RREADY,
  output logic [1:0]  GRANT,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_ADDR = 3'b010,
    S_DATA = 3'b100
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     r_state;
  logic [1:0] r_grant;
  logic [3:0] r_starve_cnt;

  logic w_in_addr;
  logic w_in_data;
  logic w_m1_wins;
  logic w_last_beat;

  assign w_in_addr   = (r_state == S_ADDR);
  assign w_in_data   = (r_state == S_DATA);
  assign w_m1_wins   = M1_ARVALID & (~M0_ARVALID | (r_starve_cnt == LIMIT));
  assign w_last_beat = RVALID & RREADY & RLAST;

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_starve_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Counter only tracks M0 wins while M1 is actually waiting.
          if (!M1_ARVALID)
            r_starve_cnt <= '0;
          if (M0_ARVALID || M1_ARVALID) begin
            r_state <= S_ADDR;
            if (w_m1_wins) begin
              r_grant      <= 2'b10;
              r_starve_cnt <= '0;
            end else begin
              r_grant <= 2'b01;
              if (M1_ARVALID && (r_starve_cnt != LIMIT))
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
          end
        end
        S_ADDR: begin
          if (ARVALID && ARREADY)
            r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_last_beat) begin
            r_state <= S_IDLE;
            r_grant <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign GRANT = r_grant;
  assign BUSY  = w_in_addr | w_in_data;

  assign ARVALID = w_in_addr & (r_grant[1] ? M1_ARVALID : M0_ARVALID);
  assign ARADDR  = w_in_addr ? (r_grant[1] ? M1_ARADDR : M0_ARADDR) : '0;

  assign M0_ARREADY = w_in_addr & r_grant[0] & ARREADY;
  assign M1_ARREADY = w_in_addr & r_grant[1] & ARREADY;

  assign RREADY    = w_in_data & (r_grant[1] ? M1_RREADY : M0_RREADY);
  assign M0_RVALID = w_in_data & r_grant[0] & RVALID;
  assign M1_RVALID = w_in_data & r_grant[1] & RVALID;
  assign M0_RLAST  = w_in_data & r_grant[0] & RLAST;
  assign M1_RLAST  = w_in_data & r_grant[1] & RLAST;

endmodule

// File: tb/tb_vram_rd_arb.sv
// Directed bench for vram_rd_arb: single bursts, starvation rotation, AR/R backpressure,
// mid-burst reset and stray read data.
module tb_vram_rd_arb;

  logic        ACLK = 1'b0;
  logic        ARST;
  logic [31:0] M0_ARADDR, M1_ARADDR, ARADDR;
  logic        M0_ARVALID, M0_ARREADY, M0_RVALID, M0_RLAST, M0_RREADY;
  logic        M1_ARVALID, M1_ARREADY, M1_RVALID, M1_RLAST, M1_RREADY;
  logic        ARVALID, ARREADY, RVALID, RLAST, RREADY, BUSY;
  logic [1:0]  GRANT;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ACLK = ~ACLK;

  vram_rd_arb #(.STARVE_LIMIT(4)) dut (
    .ACLK(ACLK), .ARST(ARST),
    .M0_ARADDR(M0_ARADDR), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
    .M0_RVALID(M0_RVALID), .M0_RLAST(M0_RLAST), .M0_RREADY(M0_RREADY),
    .M1_ARADDR(M1_ARADDR), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
    .M1_RVALID(M1_RVALID), .M1_RLAST(M1_RLAST), .M1_RREADY(M1_RREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY),
    .GRANT(GRANT), .BUSY(BUSY)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {22'd0, GRANT, BUSY, ARVALID, RREADY, M0_ARREADY, M1_ARREADY,
                          M0_RVALID, M1_RVALID, M0_RLAST, M1_RLAST}, 32'd0);
    check({tag, "_araddr"}, ARADDR, 32'd0);
  endtask

  // Entered in IDLE with requests already driven; leaves in the IDLE cycle after RLAST.
  task automatic run_burst(input logic [1:0] g, input logic [31:0] a, input int beats,
                           input bit drop_req, input string tag);
    int got = 0;
    #1;
    check({tag, "_pre_arvalid"}, ARVALID, 0);
    check({tag, "_pre_busy"}, BUSY, 0);
    step();
    check({tag, "_grant"}, GRANT, g);
    check({tag, "_arvalid"}, ARVALID, 1);
    check({tag, "_araddr"}, ARADDR, a);
    ARREADY = 1'b1;
    #1;
    check({tag, "_arready"}, {M1_ARREADY, M0_ARREADY}, g);
    step();
    ARREADY = 1'b0;
    if (drop_req) begin
      M0_ARVALID = 1'b0;
      M1_ARVALID = 1'b0;
    end
    for (int i = 0; i < beats; i++) begin
      RVALID    = 1'b1;
      RLAST     = (i == beats - 1);
      M0_RREADY = g[0];
      M1_RREADY = g[1];
      #1;
      check({tag, "_rvalid"}, {M1_RVALID, M0_RVALID}, g);
      check({tag, "_rlast"}, {M1_RLAST, M0_RLAST}, RLAST ? {30'd0, g} : 32'd0);
      if ((g[0] ? M0_RVALID : M1_RVALID) && RREADY) got++;
      step();
    end
    RVALID = 1'b0; RLAST = 1'b0; M0_RREADY = 1'b0; M1_RREADY = 1'b0;
    #1;
    check({tag, "_beats"}, got, beats);
    check({tag, "_end_grant"}, GRANT, 0);
    check({tag, "_end_busy"}, BUSY, 0);
  endtask

  logic [1:0] exp_seq [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                               2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
  logic       rr_pat  [5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic       rl_pat  [5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    ARST = 1'b1;
    M0_ARADDR = 32'h1000_0000; M1_ARADDR = 32'h2000_0040;
    M0_ARVALID = 1'b1; M1_ARVALID = 1'b1; M0_RREADY = 1'b1; M1_RREADY = 1'b1;
    ARREADY = 1'b1; RVALID = 1'b1; RLAST = 1'b1;

    // Reset with every input active: all handshake outputs stay low.
    step(); check_quiet("rst_a");
    step(); check_quiet("rst_b");
    M0_ARVALID = 1'b0; M1_ARVALID = 1'b0; M0_RREADY = 1'b0; M1_RREADY = 1'b0;
    ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
    ARST = 1'b0;
    step(); check_quiet("post_rst");

    // Single M0 8-beat burst.
    M0_ARVALID = 1'b1;
    run_burst(2'b01, 32'h1000_0000, 8, 1'b1, "m0_single");

    // M1 burst with AR stall and R backpressure while M0 waits.
    M1_ARVALID = 1'b1;
    step();
    check("stall_grant0", GRANT, 2'b10);
    M0_ARVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_arvalid", ARVALID, 1);
      check("stall_araddr", ARADDR, 32'h2000_0040);
      check("stall_grant", GRANT, 2'b10);
      check("stall_arready", {M1_ARREADY, M0_ARREADY}, 2'b00);
    end
    ARREADY = 1'b1;
    #1;
    check("stall_release", {M1_ARREADY, M0_ARREADY}, 2'b10);
    step();
    ARREADY = 1'b0; M1_ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      RVALID = 1'b1; RLAST = rl_pat[i]; M1_RREADY = rr_pat[i];
      #1;
      check("bp_rready", RREADY, rr_pat[i]);
      check("bp_other_rvalid", M0_RVALID, 0);
      check("bp_busy", BUSY, 1);
      step();
    end
    RVALID = 1'b0; RLAST = 1'b0; M1_RREADY = 1'b0;
    #1;
    check("gap_grant", GRANT, 0);
    check("gap_busy", BUSY, 0);
    run_burst(2'b01, 32'h1000_0000, 1, 1'b1, "m0_after_m1");

    // Both requesting continuously: four M0 grants then one M1.
    M0_ARVALID = 1'b1; M1_ARVALID = 1'b1;
    for (int i = 0; i < 10; i++)
      run_burst(exp_seq[i], exp_seq[i][1] ? 32'h2000_0040 : 32'h1000_0000, 1, 1'b0, "starve");
    M0_ARVALID = 1'b0; M1_ARVALID = 1'b0;
    step();

    // Reset on the third beat of an M1 burst.
    M1_ARVALID = 1'b1;
    step();
    check("mid_grant", GRANT, 2'b10);
    ARREADY = 1'b1;
    step();
    ARREADY = 1'b0; M1_ARVALID = 1'b0;
    RVALID = 1'b1; M1_RREADY = 1'b1;
    step();
    step();
    check("mid_beat3", M1_RVALID, 1);
    ARST = 1'b1; M0_ARVALID = 1'b1; M1_ARVALID = 1'b1; ARREADY = 1'b1;
    step();
    check_quiet("mid_rst");
    ARST = 1'b0; RVALID = 1'b0; M1_RREADY = 1'b0; ARREADY = 1'b0;
    step();
    check("rel_grant", GRANT, 2'b01);
    check("rel_araddr", ARADDR, 32'h1000_0000);
    ARST = 1'b1; M0_ARVALID = 1'b0; M1_ARVALID = 1'b0;
    step();
    ARST = 1'b0;
    step();

    // Stray read data while idle must not be accepted or forwarded.
    RVALID = 1'b1; RLAST = 1'b1; M0_RREADY = 1'b1; M1_RREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_quiet("stray");
      step();
    end
    RVALID = 1'b0; RLAST = 1'b0; M0_RREADY = 1'b0; M1_RREADY = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
